// File: rtl/vga_pkg.sv
// Shared pixel types and screen geometry for the VGA pixel path.
package vga_pkg;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int COL_W = 9;

  localparam logic [X_W-1:0] SCREEN_W = 8'd160;
  localparam logic [Y_W-1:0] SCREEN_H = 7'd120;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [COL_W-1:0] colour;
  } pixel_t;

  typedef enum logic {
    GNT_ERASE = 1'b0,
    GNT_DRAW  = 1'b1
  } grant_e;

  function automatic logic on_screen(input pixel_t p);
    return (p.x < SCREEN_W) && (p.y < SCREEN_H);
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// DEPTH-entry pixel FIFO with occupancy count; head reads as zero when empty.
module pixel_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  pixel_t                   push_data,
  input  logic                     pop,
  output pixel_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if (!(DEPTH == 2 || DEPTH == 4 || DEPTH == 8)) begin : g_bad_depth
    $error("pixel_fifo: DEPTH must be 2, 4 or 8");
  end

  pixel_t          mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic            empty, do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointer wrap is plain binary rollover.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vga_pixel_mux.sv
// Round-robin merge of erase/draw pixel streams into a FIFO feeding the VGA write port.
// Define VGA_PIXEL_CLIP_EN to drop (after handshake) pixels outside the 160x120 screen.
module vga_pixel_mux
  import vga_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    erase_valid,
  input  logic [X_W-1:0]          erase_x,
  input  logic [Y_W-1:0]          erase_y,
  input  logic [COL_W-1:0]        erase_colour,
  output logic                    erase_ready,
  input  logic                    draw_valid,
  input  logic [X_W-1:0]          draw_x,
  input  logic [Y_W-1:0]          draw_y,
  input  logic [COL_W-1:0]        draw_colour,
  output logic                    draw_ready,
  input  logic                    hold,
  output logic                    plot,
  output logic [X_W-1:0]          x,
  output logic [Y_W-1:0]          y,
  output logic [COL_W-1:0]        colour,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  pixel_t erase_pix, draw_pix, push_pix, head;
  grant_e last_grant;
  logic   full, erase_xfer, draw_xfer, push;

  assign erase_pix = '{x: erase_x, y: erase_y, colour: erase_colour};
  assign draw_pix  = '{x: draw_x,  y: draw_y,  colour: draw_colour};

  // Readiness depends only on the registered count, so a same-cycle pop never frees a slot.
  always_comb begin
    erase_ready = 1'b0;
    draw_ready  = 1'b0;
    if (resetn && !full) begin
      if (erase_valid && draw_valid) begin
        if (last_grant == GNT_DRAW) erase_ready = 1'b1;
        else                        draw_ready  = 1'b1;
      end else begin
        erase_ready = erase_valid;
        draw_ready  = draw_valid;
      end
    end
  end

  assign erase_xfer = erase_valid && erase_ready;
  assign draw_xfer  = draw_valid && draw_ready;
  assign push_pix   = draw_xfer ? draw_pix : erase_pix;

`ifdef VGA_PIXEL_CLIP_EN
  assign push = (erase_xfer || draw_xfer) && on_screen(push_pix);
`else
  assign push = erase_xfer || draw_xfer;
`endif

  always_ff @(posedge clk) begin
    if (!resetn)         last_grant <= GNT_DRAW;
    else if (erase_xfer) last_grant <= GNT_ERASE;
    else if (draw_xfer)  last_grant <= GNT_DRAW;
  end

  pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (push_pix),
    .pop       (plot),
    .head      (head),
    .count     (fifo_count),
    .full      (full)
  );

  assign plot   = (fifo_count != '0) && !hold;
  assign x      = head.x;
  assign y      = head.y;
  assign colour = head.colour;

endmodule

// File: doc/vga_pixel_mux.md
VGA_PIXEL_MUX -- requirements
Module: vga_pixel_mux

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entries; the legal values are 2, 4 and 8.
REQ-002 SHALL have port clk, input, 1 bit, system clock, rising edge.
REQ-003 SHALL have port resetn, input, 1 bit, synchronous active-low reset.
REQ-004 SHALL have port erase_valid, input, 1 bit, which signals that the erase source is presenting a pixel.
REQ-005 SHALL have ports erase_x (input, 8 bits), erase_y (input, 7 bits) and erase_colour (input, 9 bits), which carry the erase source pixel.
REQ-006 SHALL have port erase_ready, output, 1 bit, which signals that the erase pixel is accepted this cycle.
REQ-007 SHALL have ports draw_valid, draw_x[7:0], draw_y[6:0], draw_colour[8:0] (all inputs) and draw_ready (output), with the same meanings for the draw source.
REQ-008 SHALL have port hold, input, 1 bit, which stalls output while 1 (adapter busy or frame sync).
REQ-009 SHALL have ports plot (output, 1 bit), x (output, 8 bits), y (output, 7 bits) and colour (output, 9 bits), which feed the VGA adapter write port.
REQ-010 SHALL have port fifo_count, output, clog2(DEPTH)+1 bits, which gives the current occupancy.

Function
REQ-011 A source transfer SHALL occur on a clk edge where its valid and ready are both 1.
REQ-012 Both readys SHALL be 0 when the registered fifo_count equals DEPTH; a pop in the same cycle SHALL NOT free a slot until the next cycle.
REQ-013 When the FIFO is not full, at most one ready SHALL be 1 per cycle.
- If only one source is valid, that source's ready SHALL be 1.
- If both sources are valid, round-robin arbitration SHALL apply: grant goes to the source not granted last.
- If neither source is valid, both readys SHALL be 0.
REQ-014 The last-grant register SHALL update only on an actual transfer.
REQ-015 A source that is not granted SHALL hold its pixel stable; the mux SHALL NOT drop pixels, except as stated in REQ-024.
REQ-016 Push order SHALL equal transfer order; the output order SHALL be strict FIFO.
REQ-017 plot SHALL equal (fifo_count != 0) && !hold; x, y and colour SHALL show the head entry whenever the FIFO is non-empty, and all-zeros when it is empty.
REQ-018 Pop SHALL occur on each edge where plot is 1.
REQ-019 Latency from transfer to plot SHALL be exactly 1 cycle with an empty FIFO and hold at 0.
REQ-020 Simultaneous push and pop SHALL leave fifo_count unchanged and SHALL be legal at any non-full occupancy, including 0 → push-only effect visible next cycle.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH; fifo_count SHALL be range 0..DEPTH and SHALL NOT overflow or underflow.
REQ-022 hold SHALL NOT affect readys; the FIFO SHALL fill to DEPTH under sustained hold and then backpressure both sources.

Reset
REQ-023 With resetn at 0 on an edge, the mux SHALL apply these reset values:
- fifo_count = 0, with both pointers = 0.
- plot = 0, with x, y and colour = 0.
- last-grant = draw, so erase wins the first contention.
- Mid-operation reset SHALL discard all buffered pixels.
- The readys SHALL be 0 while resetn is 0.

Configuration
REQ-024 With macro VGA_PIXEL_CLIP_EN defined, a transferred pixel with x>=160 or y>=120 SHALL complete its handshake but SHALL NOT be pushed; fifo_count and last-grant SHALL still follow REQ-014.
REQ-025 Without VGA_PIXEL_CLIP_EN, every transferred pixel SHALL be pushed unmodified.

Structure
REQ-026 Shared package vga_pkg SHALL hold X_W=8, Y_W=7, COL_W=9, SCREEN_W=160, SCREEN_H=120 and the pixel struct/typedef {x, y, colour}.
REQ-027 Storage SHALL be the sub-module pixel_fifo (DEPTH-entry, 24-bit, count/pointer logic); arbitration and clip logic SHALL reside in vga_pixel_mux.

Verification
REQ-028 Scenario: single erase pixel (39,39,0x1A5), hold=0 → erase_ready=1 same cycle; next cycle plot=1, x=39, y=39, colour=0x1A5; following cycle plot=0.
REQ-029 Scenario: both valid continuously after reset, with 6 pixels each → grants alternate erase, draw, erase,…; output order matches grant order.
REQ-030 Scenario: hold=1 with erase streaming at DEPTH=4 → 4 accepted, fifo_count=4, erase_ready=0; release hold → 4 plots on consecutive cycles, ready returns the cycle after the first pop.
REQ-031 Scenario: FIFO at count 2, push and pop in the same cycle → count stays 2, and the data order is preserved across the pointer wrap.
REQ-032 Scenario: resetn=0 for 1 cycle with count=3 → next cycle plot=0, fifo_count=0, x/y/colour=0, and the earlier entries never appear.
REQ-033 Scenario: with VGA_PIXEL_CLIP_EN, draw pixel (200,50) and then (159,119) → both handshake; only (159,119) plotted; fifo_count peaks at 1.
